blinker_period_decoder: RTL

- Receive-side counterpart to the blinker: takes a 1-bit blink/toggle stream and decodes its timing.
- Per rising-to-rising interval, reports the full period and the high time, in clock cycles.
- Results go out through a single-entry valid/ready slot.
- Sits downstream of a blinker output (same clock domain) to check or recover the blink rate.

---
 rtl/blinker_period_decoder_if.sv | 33 +++
 rtl/blinker_period_decoder.sv | 130 +++++++++++++
 2 files changed

// File: rtl/blinker_period_decoder_if.sv
// Result bus of the blink-period decoder: blink stream in, period/high result out through a valid/ready slot.
// master = stream source and result consumer, slave = decoder.
interface blinker_period_decoder_if #(
  parameter int W = 16
) ();
  logic         sig_i1;
  logic         ready_i1;
  logic [W-1:0] period_o;
  logic [W-1:0] high_o;
  logic         valid_o;
  logic         drop_o;
  logic         timeout_o;

  modport master (
    output sig_i1,
    output ready_i1,
    input  period_o,
    input  high_o,
    input  valid_o,
    input  drop_o,
    input  timeout_o
  );

  modport slave (
    input  sig_i1,
    input  ready_i1,
    output period_o,
    output high_o,
    output valid_o,
    output drop_o,
    output timeout_o
  );
endinterface

// File: rtl/blinker_period_decoder.sv
// Measures period and high time of a blink stream per rise-to-rise interval; result 1 cycle after the closing rise.
// Single-entry output slot: a capture while the slot is full and stalled is discarded and flagged on drop_o.
module blinker_period_decoder #(
  parameter int W = 16
) (
  input  logic                    system1000,
  input  logic                    system1000_rstn,
  blinker_period_decoder_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_t;

  // Last count value before the counter would reach all-ones; the interval is abandoned there.
  localparam logic [W-1:0] CNT_LAST = {{(W-1){1'b1}}, 1'b0};
  localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

  state_t       state_q, state_d;
  logic         s_q;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] hcnt_q, hcnt_d;
  logic [W-1:0] period_q, period_d;
  logic [W-1:0] high_q, high_d;
  logic         valid_q, valid_d;
  logic         drop_q, drop_d;
  logic         timeout_q, timeout_d;

  logic         rise;
  logic         capture;
  logic         expire;

  assign rise = bus.sig_i1 & ~s_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;
    capture = 1'b0;
    expire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = MEAS;
          cnt_d   = CNT_ONE;
          hcnt_d  = CNT_ONE;
        end
      end
      MEAS: begin
        if (rise) begin
          capture = 1'b1;
          cnt_d   = CNT_ONE;
          hcnt_d  = CNT_ONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          hcnt_d  = '0;
          expire  = 1'b1;
        end else begin
          cnt_d  = cnt_q + CNT_ONE;
          hcnt_d = hcnt_q + {{(W-1){1'b0}}, bus.sig_i1};
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        hcnt_d  = '0;
      end
    endcase
  end

  // Output slot: draining and loading in the same cycle loses nothing.
  always_comb begin
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = valid_q;
    drop_d    = 1'b0;
    timeout_d = expire;
    if (capture) begin
      if (!valid_q || bus.ready_i1) begin
        period_d = cnt_q;
        high_d   = hcnt_q;
        valid_d  = 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end else if (valid_q && bus.ready_i1) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state_q   <= IDLE;
      s_q       <= 1'b0;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      drop_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= bus.sig_i1;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      drop_q    <= drop_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.period_o  = period_q;
  assign bus.high_o    = high_q;
  assign bus.valid_o   = valid_q;
  assign bus.drop_o    = drop_q;
  assign bus.timeout_o = timeout_q;

  a_high_le_period: assert property (@(posedge system1000) disable iff (!system1000_rstn)
    hcnt_q <= cnt_q);
  a_stall_stable: assert property (@(posedge system1000) disable iff (!system1000_rstn)
    (valid_q && !bus.ready_i1) |=> (valid_q && $stable(period_q) && $stable(high_q)));
  a_drop_timeout_excl: assert property (@(posedge system1000) disable iff (!system1000_rstn)
    !(drop_q && timeout_q));

endmodule
